// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the IFU/LSU memory bus arbiter.
// Segment decode, exception ids and FSM/owner enums live here.
package mem_bus_arbiter_pkg;

    localparam logic [31:0] SEGMENT_MASK = 32'hF000_0000;
    localparam logic [31:0] TEXT_SEGMENT = 32'h0000_0000;
    localparam logic [31:0] DATA_SEGMENT = 32'h1000_0000;
    localparam logic [31:0] DEVI_SEGMENT = 32'hF000_0000;

    localparam logic [4:0] EXCEPT_NONE       = 5'd0;
    localparam logic [4:0] EXCEPT_RD_INVALID = 5'd5;
    localparam logic [4:0] EXCEPT_WR_INVALID = 5'd7;

    localparam logic [2:0] WORD_WIDE = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

    typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_t;

    typedef enum logic [1:0] {SEG_TEXT, SEG_DATA, SEG_DEVI, SEG_OTHER} seg_t;

    function automatic seg_t seg_decode(input logic [31:0] addr);
        logic [31:0] seg;
        seg = addr & SEGMENT_MASK;
        if (seg == DEVI_SEGMENT) begin
            return SEG_DEVI;
        end else if (seg == TEXT_SEGMENT) begin
            return SEG_TEXT;
        end else if (seg == DATA_SEGMENT) begin
            return SEG_DATA;
        end
        return SEG_OTHER;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a conflict
// goes to whichever requester did not own the bus last.
module rr_pick2
    import mem_bus_arbiter_pkg::*;
(
    input  logic       req_ifu_i,
    input  logic       req_lsu_i,
    input  arb_owner_t last_i,
    output logic       valid_o,
    output arb_owner_t pick_o
);

    always_comb begin
        valid_o = req_ifu_i | req_lsu_i;
        pick_o  = OWN_IFU;
        if (req_ifu_i && req_lsu_i) begin
            pick_o = (last_i == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (req_lsu_i) begin
            pick_o = OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one MMU port between IFU and LSU, one transaction at a time.
// Memory segments finish after MEM_LATENCY cycles, devices on ready or timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,

    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [2:0]  lsu_mode,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic [4:0]  lsu_errid,

    output logic        m_en,
    output logic        m_wen,
    output logic [31:0] m_r_addr,
    output logic [31:0] m_w_addr,
    output logic [2:0]  m_r_mode,
    output logic [2:0]  m_w_mode,
    output logic [31:0] m_w_data,
    input  logic [31:0] m_r_data,
    input  logic        m_r_ready,
    input  logic        m_w_ready,
    input  logic        m_err,
    input  logic [4:0]  m_errid
);

    localparam logic [CNT_W-1:0] MemLast = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] DevLast = CNT_W'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    arb_owner_t       last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       mode_q, mode_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             ifu_gnt_q, ifu_gnt_d;
    logic             lsu_gnt_q, lsu_gnt_d;
    logic             ifu_valid_q, ifu_valid_d;
    logic             lsu_valid_q, lsu_valid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [4:0]       errid_q, errid_d;

    logic             gnt_pending;
    logic             arb_ok;
    arb_owner_t       last_eff;
    logic             pick_valid;
    arb_owner_t       pick_owner;
    logic             seg_devi;
    logic             dev_ready;
    logic             done;
    logic             done_err;
    logic [4:0]       done_errid;

    rr_pick2 u_pick (
        .req_ifu_i (ifu_req),
        .req_lsu_i (lsu_req),
        .last_i    (last_eff),
        .valid_o   (pick_valid),
        .pick_o    (pick_owner)
    );

    // A grant pulse is held one cycle in IDLE before BUSY starts, so arbitration
    // runs in IDLE without a pending grant, and also at the DONE->IDLE edge so a
    // waiting requester is granted back-to-back.
    assign gnt_pending = ifu_gnt_q | lsu_gnt_q;
    assign arb_ok      = (state_q == DONE) || ((state_q == IDLE) && !gnt_pending);
    assign last_eff    = (state_q == DONE) ? owner_q : last_owner_q;
    assign seg_devi    = (seg_decode(addr_q) == SEG_DEVI);
    assign dev_ready   = we_q ? m_w_ready : m_r_ready;

    // Completion priority: MMU error, device ready, memory latency, device timeout.
    always_comb begin
        done       = 1'b0;
        done_err   = 1'b0;
        done_errid = EXCEPT_NONE;
        if (state_q == BUSY) begin
            if (m_err) begin
                done       = 1'b1;
                done_err   = 1'b1;
                done_errid = m_errid;
            end else if (seg_devi && dev_ready) begin
                done = 1'b1;
            end else if (!seg_devi && (cnt_q == MemLast)) begin
                done = 1'b1;
            end else if (seg_devi && (cnt_q == DevLast)) begin
                done       = 1'b1;
                done_err   = 1'b1;
                done_errid = we_q ? EXCEPT_WR_INVALID : EXCEPT_RD_INVALID;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_pending) state_d = BUSY;
            BUSY:    if (done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        last_owner_d = (state_q == DONE) ? owner_q : last_owner_q;
        cnt_d        = (state_q == BUSY) ? cnt_q + CNT_W'(1) : '0;
        addr_d       = addr_q;
        mode_d       = mode_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        ifu_gnt_d    = 1'b0;
        lsu_gnt_d    = 1'b0;
        ifu_valid_d  = 1'b0;
        lsu_valid_d  = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        errid_d      = errid_q;

        if (arb_ok && pick_valid) begin
            owner_d = pick_owner;
            if (pick_owner == OWN_LSU) begin
                lsu_gnt_d = 1'b1;
                addr_d    = lsu_addr;
                mode_d    = lsu_mode;
                we_d      = lsu_we;
                wdata_d   = lsu_wdata;
            end else begin
                ifu_gnt_d = 1'b1;
                addr_d    = ifu_addr;
                mode_d    = WORD_WIDE;
                we_d      = 1'b0;
                wdata_d   = '0;
            end
        end

        if (done) begin
            ifu_valid_d = (owner_q == OWN_IFU);
            lsu_valid_d = (owner_q == OWN_LSU);
            rdata_d     = done_err ? '0 : m_r_data;
            err_d       = done_err;
            errid_d     = done_errid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OWN_IFU;
            last_owner_q <= OWN_IFU;
            cnt_q        <= '0;
            addr_q       <= '0;
            mode_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            ifu_gnt_q    <= 1'b0;
            lsu_gnt_q    <= 1'b0;
            ifu_valid_q  <= 1'b0;
            lsu_valid_q  <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            errid_q      <= '0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            mode_q       <= mode_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            ifu_gnt_q    <= ifu_gnt_d;
            lsu_gnt_q    <= lsu_gnt_d;
            ifu_valid_q  <= ifu_valid_d;
            lsu_valid_q  <= lsu_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            errid_q      <= errid_d;
        end
    end

    // m_en only in BUSY keeps side-effecting device reads single-shot.
    always_comb begin
        m_en      = (state_q == BUSY);
        m_wen     = (state_q == BUSY) & we_q;
        m_r_addr  = addr_q;
        m_w_addr  = addr_q;
        m_r_mode  = mode_q;
        m_w_mode  = mode_q;
        m_w_data  = wdata_q;
        ifu_gnt   = ifu_gnt_q;
        lsu_gnt   = lsu_gnt_q;
        ifu_valid = ifu_valid_q;
        lsu_valid = lsu_valid_q;
        ifu_rdata = ifu_valid_q ? rdata_q : '0;
        ifu_err   = ifu_valid_q & err_q;
        lsu_rdata = lsu_valid_q ? rdata_q : '0;
        lsu_err   = lsu_valid_q & err_q;
        lsu_errid = lsu_valid_q ? errid_q : '0;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester sequencer in front of the memory/device MMU. It shares the single MMU port between the instruction-fetch unit (IFU) and the load/store unit (LSU), and runs exactly one transaction at a time. Memory-segment accesses complete after a fixed latency. Device-segment accesses complete on the MMU ready strobe, bounded by a timeout. Each requester sees a request/grant handshake followed by a one-cycle response pulse.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from issue to valid `m_r_data` for TEXT/DATA segments; legal range ≥1.
- `TIMEOUT`, default 255: maximum device-segment wait cycles before error; must be > `MEM_LATENCY`.
- `CNT_W`, default 8: wait-counter width; must satisfy 2^`CNT_W` > `TIMEOUT`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ifu_req` in 1: fetch request; held until granted.
- `ifu_addr` in 32: fetch address.
- `ifu_gnt` out 1: one-cycle pulse; request fields latched this cycle.
- `ifu_valid` out 1: one-cycle response pulse.
- `ifu_rdata` out 32: read data; valid with `ifu_valid`.
- `ifu_err` out 1: error flag; valid with `ifu_valid`.
- `lsu_req` in 1: load/store request; held until granted.
- `lsu_we` in 1: 1 = store.
- `lsu_addr` in 32: load/store address.
- `lsu_mode` in 3: access mode, byte/half/word plus sign.
- `lsu_wdata` in 32: store data.
- `lsu_gnt` out 1: one-cycle grant pulse.
- `lsu_valid` out 1: one-cycle response pulse.
- `lsu_rdata` out 32: read data; valid with `lsu_valid`.
- `lsu_err` out 1: error flag; valid with `lsu_valid`.
- `lsu_errid` out 5: exception id; valid with `lsu_valid`.
- `m_en`, `m_wen` out 1: MMU enable and write enable.
- `m_r_addr`, `m_w_addr` out 32: both driven from the same latched address.
- `m_r_mode`, `m_w_mode` out 3: both driven from the same latched mode.
- `m_w_data` out 32: MMU write data.
- `m_r_data` in 32; `m_r_ready`, `m_w_ready`, `m_err` in 1; `m_errid` in 5: MMU responses.

## Operation
- State machine: IDLE → BUSY → DONE → IDLE.
- IDLE:
  - Owner selection: if only one requester is active, grant it. If both are active, grant the one not recorded in `last_owner` (round-robin).
  - On grant: pulse `*_gnt`, latch addr/mode/we/wdata/owner, clear counter, go to BUSY.
- IFU fetches are latched as read, mode = word (`3'b010`).
- BUSY:
  - Drive `m_en`=1, `m_wen`=latched we; counter increments every cycle.
  - Completion priority, evaluated each cycle:
    1. `m_err`=1 → record err=1, errid=`m_errid`.
    2. Segment is DEVI: `m_r_ready` (read) or `m_w_ready` (write) → capture `m_r_data`, err=0.
    3. Segment is TEXT/DATA/other and counter == `MEM_LATENCY`-1 → capture `m_r_data`, err=0.
    4. DEVI and counter == `TIMEOUT`-1 → err=1, errid=`EXCEPT_RD_INVALID` (read) or `EXCEPT_WR_INVALID` (write).
  - On any completion, go to DONE.
- DONE:
  - `m_en`=`m_wen`=0.
  - Pulse the owner's `*_valid` with the captured rdata/err/errid; update `last_owner`; go to IDLE.
- `m_en` is high only in BUSY, so a side-effecting keyboard read is consumed exactly once.
- Outputs of the non-owner requester stay 0, including rdata.

## Timing
- Reset (async): state IDLE, `last_owner`=IFU (so the first conflict grants LSU), counter 0.
- All outputs are 0 during and after reset until the next grant.
- Reset mid-BUSY aborts the transaction and emits no `valid`; the requester re-requests.
- Grant is in cycle t; `m_en` is high t+1 .. t+L, where L = `MEM_LATENCY` for memory segments.
- `valid` is at t+L+1; the next grant is possible at t+L+2.
- Requests arriving during BUSY/DONE wait; `req` must stay high until `gnt`.
- `*_gnt` and `*_valid` are registered outputs; no combinational path from `*_req` to `m_*`.

## Structure
- Shared config package/header holds:
  - `SEGMENT_MASK`, `DEVI_SEGMENT`, `TEXT_SEGMENT`, `DATA_SEGMENT`, `EXCEPT_*` codes, `WORD_WIDE`.
  - New FSM state enum `arb_state_t` {IDLE, BUSY, DONE}.
  - Owner enum `arb_owner_t` {OWN_IFU, OWN_LSU}.
- One sub-module, `rr_pick2`: 2-way round-robin selector; combinational pick from two requests and the last owner.

## Test plan
- Lone IFU fetch of `0x0000_0040`, `m_r_data`=`0x1234_5678`, `MEM_LATENCY`=1 → `ifu_gnt` at t, `m_en` at t+1 only, `ifu_valid` at t+2 with rdata `0x1234_5678`, `ifu_err`=0.
- IFU and LSU both request in the same cycle after reset → LSU granted first. IFU granted in the next IDLE; a third simultaneous pair → LSU again (alternation).
- LSU DEVI keyboard read; `m_r_ready` rises 5 cycles into BUSY with data `0x0000_0041` → `lsu_valid` next cycle with rdata `0x41`; `m_en` high for exactly 5 cycles.
- LSU DEVI store; `m_w_ready` never asserted, `TIMEOUT`=16 → `lsu_valid` 17 cycles after grant, `lsu_err`=1, errid=`EXCEPT_WR_INVALID`.
- LSU store with `m_err`=1, `m_errid`=`EXCEPT_WR_INVALID` in the first BUSY cycle → immediate DONE, `lsu_err`=1, errid passed through.
- `rst` asserted mid-BUSY → outputs 0 asynchronously, no `valid` pulse; the post-reset request is granted normally.
